// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture block: default counter width
// and the measurement FSM state encoding.
package pwm_pkg;

  // Base counter width, matching the PWM generator duty width.
  localparam int CNT_W_DEFAULT = 12;

  // Measurement FSM: wait for a first rise, then track the high and low phases.
  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    HIGH      = 2'd1,
    LOW       = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/pwm_sync.sv
// Input conditioning for pwm_capture: a 2-flop synchronizer, an optional
// glitch filter, and rise/fall detection against a one-cycle delayed level.
// Build option: define PWM_CAPTURE_FILTER_EN to require three consecutive
// identical synchronized samples before the level may change.
module pwm_sync (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync1_r;
  logic sync2_r;
  logic level_r;
  logic level_d_r;

  // Two-flop synchronizer for the asynchronous PWM input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= pwm_in;
      sync2_r <= sync1_r;
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  logic hist1_r;
  logic hist2_r;

  // Level follows the synchronized input only after three identical samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist1_r <= 1'b0;
      hist2_r <= 1'b0;
      level_r <= 1'b0;
    end else begin
      hist1_r <= sync2_r;
      hist2_r <= hist1_r;
      if ((sync2_r == hist1_r) && (hist1_r == hist2_r)) begin
        level_r <= sync2_r;
      end else begin
        level_r <= level_r;
      end
    end
  end
`else
  // Unfiltered: level is a registered copy of the synchronizer output.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_r <= 1'b0;
    end else begin
      level_r <= sync2_r;
    end
  end
`endif

  // Delayed copy of the level, used for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_d_r <= 1'b0;
    end else begin
      level_d_r <= level_r;
    end
  end

  assign level = level_r;
  assign rise  = level_r & ~level_d_r;
  assign fall  = ~level_r & level_d_r;

endmodule

// File: rtl/pwm_capture.sv
// PWM duty/period capture. Measures rising edge to rising edge and reports
// the high time and period of each complete cycle with a one-cycle valid.
// Counters saturate; reaching saturation flags a stuck input instead.
// Build option: PWM_CAPTURE_FILTER_EN enables the input glitch filter.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pwm_in,
  output logic [CNT_W:0] duty,
  output logic [CNT_W:0] period,
  output logic           valid,
  output logic           stuck_hi,
  output logic           stuck_lo,
  output logic           level
);

  localparam int MW = CNT_W + 1;
  localparam logic [MW-1:0] CNT_MAX  = {MW{1'b1}};
  localparam logic [MW-1:0] CNT_ONE  = {{(MW-1){1'b0}}, 1'b1};
  localparam logic [MW-1:0] CNT_ZERO = {MW{1'b0}};

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [MW-1:0] sat_inc(input logic [MW-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  logic          level_s;
  logic          rise_s;
  logic          fall_s;
  logic          sat_s;
  logic          capture_s;
  logic          stuck_set_s;
  pwm_state_e    state_r;
  pwm_state_e    state_nxt_s;
  logic [MW-1:0] period_cnt_r;
  logic [MW-1:0] high_cnt_r;
  logic [MW-1:0] duty_r;
  logic [MW-1:0] period_r;
  logic          valid_r;
  logic          stuck_hi_r;
  logic          stuck_lo_r;

  pwm_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (pwm_in),
    .level  (level_s),
    .rise   (rise_s),
    .fall   (fall_s)
  );

  assign sat_s = (period_cnt_r == CNT_MAX);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= WAIT_RISE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: a rise always wins over saturation in the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      WAIT_RISE: begin
        if (rise_s) begin
          state_nxt_s = HIGH;
        end else begin
          state_nxt_s = WAIT_RISE;
        end
      end
      HIGH: begin
        if (rise_s) begin
          state_nxt_s = HIGH;
        end else if (sat_s) begin
          state_nxt_s = WAIT_RISE;
        end else if (fall_s) begin
          state_nxt_s = LOW;
        end else begin
          state_nxt_s = HIGH;
        end
      end
      LOW: begin
        if (rise_s) begin
          state_nxt_s = HIGH;
        end else if (sat_s) begin
          state_nxt_s = WAIT_RISE;
        end else begin
          state_nxt_s = LOW;
        end
      end
      default: begin
        state_nxt_s = WAIT_RISE;
      end
    endcase
  end

  // FSM outputs: capture on a rise that closes a full period, stuck on saturation.
  always_comb begin
    capture_s   = 1'b0;
    stuck_set_s = 1'b0;
    case (state_r)
      WAIT_RISE: begin
        capture_s   = 1'b0;
        stuck_set_s = 1'b0;
      end
      HIGH: begin
        capture_s   = 1'b0;
        stuck_set_s = sat_s & ~rise_s;
      end
      LOW: begin
        capture_s   = rise_s;
        stuck_set_s = sat_s & ~rise_s;
      end
      default: begin
        capture_s   = 1'b0;
        stuck_set_s = 1'b0;
      end
    endcase
  end

  // Period and high-time counters; the rise cycle itself counts as one.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt_r <= CNT_ZERO;
      high_cnt_r   <= CNT_ZERO;
    end else if (rise_s) begin
      period_cnt_r <= CNT_ONE;
      high_cnt_r   <= CNT_ONE;
    end else if ((state_r == WAIT_RISE) || stuck_set_s) begin
      period_cnt_r <= CNT_ZERO;
      high_cnt_r   <= CNT_ZERO;
    end else begin
      period_cnt_r <= sat_inc(period_cnt_r);
      if (level_s) begin
        high_cnt_r <= sat_inc(high_cnt_r);
      end else begin
        high_cnt_r <= high_cnt_r;
      end
    end
  end

  // Registered results, valid pulse and stuck flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_r     <= CNT_ZERO;
      period_r   <= CNT_ZERO;
      valid_r    <= 1'b0;
      stuck_hi_r <= 1'b0;
      stuck_lo_r <= 1'b0;
    end else begin
      valid_r <= capture_s;
      if (capture_s) begin
        duty_r   <= high_cnt_r;
        period_r <= period_cnt_r;
      end else begin
        duty_r   <= duty_r;
        period_r <= period_r;
      end
      if (rise_s) begin
        stuck_hi_r <= 1'b0;
        stuck_lo_r <= 1'b0;
      end else if (stuck_set_s) begin
        stuck_hi_r <= level_s;
        stuck_lo_r <= ~level_s;
      end else begin
        stuck_hi_r <= stuck_hi_r;
        stuck_lo_r <= stuck_lo_r;
      end
    end
  end

  assign duty     = duty_r;
  assign period   = period_r;
  assign valid    = valid_r;
  assign stuck_hi = stuck_hi_r;
  assign stuck_lo = stuck_lo_r;
  assign level    = level_s;

endmodule
